// File: rtl/key_decoder.sv
// PS/2 keyboard receiver and scan-code decoder that maps make/break codes onto
// per-player 5-button held state. Define PS2_PARITY_CHECK_EN to reject odd-parity failures.

module ps2_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          sync1_q, sync2_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The output follows the synchronised line only after FILTER_LEN cycles of disagreement.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) filt_d = sync2_q;
      else                              cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = filt_q;
endmodule

module key_decoder #(
  parameter int                          NUM_PLAYERS    = 2,
  parameter logic [NUM_PLAYERS*40-1:0]   KEYMAP         = 80'h5A_4B_3B_42_43_29_23_1C_1B_1D,
  parameter int                          FILTER_LEN     = 8,
  parameter int                          TIMEOUT_CYCLES = 100000
) (
  input  logic                       clk_50m,
  input  logic                       rst,
  input  logic                       kclk,
  input  logic                       kdata,
  output logic [NUM_PLAYERS*5-1:0]   player_btns,
  output logic                       key_valid,
  output logic [7:0]                 key_code,
  output logic                       key_break,
  output logic                       frame_err
);
  localparam int NB = NUM_PLAYERS * 5;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic kclk_f, kdata_f, fall;
  logic kclk_prev_q;

  state_t         state_q, state_d;
  logic [7:0]     shift_q, shift_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           byte_vld_q, byte_vld_d;
  logic [7:0]     byte_q, byte_d;
  logic           frame_err_q, frame_err_d;
  logic           stop_ok;
`ifdef PS2_PARITY_CHECK_EN
  logic           par_ok_q, par_ok_d;
`endif

  logic           break_pend_q, break_pend_d;
  logic           ext_pend_q, ext_pend_d;
  logic [NB-1:0]  btns_q, btns_d;
  logic           key_valid_q, key_valid_d;
  logic [7:0]     key_code_q, key_code_d;
  logic           key_break_q, key_break_d;

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(clk_50m), .rst(rst), .din(kclk), .dout(kclk_f));
  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clk(clk_50m), .rst(rst), .din(kdata), .dout(kdata_f));

  assign fall = kclk_prev_q & ~kclk_f;

  // Receive FSM: a completed byte leaves here one cycle after the stop-bit edge.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    byte_vld_d  = 1'b0;
    byte_d      = byte_q;
    frame_err_d = 1'b0;
    stop_ok     = 1'b0;
    tmo_d       = (state_q == S_IDLE || fall) ? '0 : tmo_q + 1'b1;
`ifdef PS2_PARITY_CHECK_EN
    par_ok_d    = par_ok_q;
`endif
    if (state_q != S_IDLE && !fall && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d     = S_IDLE;
      frame_err_d = 1'b1;
      tmo_d       = '0;
    end else if (fall) begin
      case (state_q)
        S_IDLE: begin
          if (!kdata_f) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        S_DATA: begin
          shift_d   = {kdata_f, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_ok_d = ^{shift_q, kdata_f};
`endif
          state_d = S_STOP;
        end
        default: begin
          state_d = S_IDLE;
`ifdef PS2_PARITY_CHECK_EN
          stop_ok = kdata_f & par_ok_q;
`else
          stop_ok = kdata_f;
`endif
          if (stop_ok) begin
            byte_vld_d = 1'b1;
            byte_d     = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      endcase
    end
  end

  // Decoder stage: prefixes only arm flags, every other byte is reported.
  always_comb begin
    break_pend_d = break_pend_q;
    ext_pend_d   = ext_pend_q;
    btns_d       = btns_q;
    key_valid_d  = 1'b0;
    key_code_d   = key_code_q;
    key_break_d  = key_break_q;
    if (byte_vld_q) begin
      if (byte_q == 8'hF0) begin
        break_pend_d = 1'b1;
      end else if (byte_q == 8'hE0) begin
        ext_pend_d = 1'b1;
      end else begin
        key_valid_d  = 1'b1;
        key_code_d   = byte_q;
        key_break_d  = break_pend_q;
        break_pend_d = 1'b0;
        ext_pend_d   = 1'b0;
        if (!ext_pend_q) begin
          for (int i = 0; i < NB; i++)
            if (KEYMAP[i*8 +: 8] == byte_q) btns_d[i] = ~break_pend_q;
        end
      end
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      kclk_prev_q  <= 1'b1;
      state_q      <= S_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      tmo_q        <= '0;
      byte_vld_q   <= 1'b0;
      byte_q       <= '0;
      frame_err_q  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_ok_q     <= 1'b0;
`endif
      break_pend_q <= 1'b0;
      ext_pend_q   <= 1'b0;
      btns_q       <= '0;
      key_valid_q  <= 1'b0;
      key_code_q   <= '0;
      key_break_q  <= 1'b0;
    end else begin
      kclk_prev_q  <= kclk_f;
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      tmo_q        <= tmo_d;
      byte_vld_q   <= byte_vld_d;
      byte_q       <= byte_d;
      frame_err_q  <= frame_err_d;
`ifdef PS2_PARITY_CHECK_EN
      par_ok_q     <= par_ok_d;
`endif
      break_pend_q <= break_pend_d;
      ext_pend_q   <= ext_pend_d;
      btns_q       <= btns_d;
      key_valid_q  <= key_valid_d;
      key_code_q   <= key_code_d;
      key_break_q  <= key_break_d;
    end
  end

  assign player_btns = btns_q;
  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign key_break   = key_break_q;
  assign frame_err   = frame_err_q;
endmodule

// File: tb/tb_key_decoder.sv
// Randomised PS/2 frame bench for key_decoder with a scan-code behavioural model
// and a per-cycle compare process.

module tb_key_decoder;
  localparam int NP  = 2;
  localparam int NB  = NP * 5;
  localparam int FL  = 8;
  localparam int TMO = 2000;
  localparam int H   = 20;
  localparam logic [NP*40-1:0] KMAP = 80'h5A_4B_3B_42_43_29_23_1C_1B_1D;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0, rst = 1'b1, kclk = 1'b1, kdata = 1'b1;
  logic [NB-1:0] player_btns;
  logic          key_valid, key_break, frame_err;
  logic [7:0]    key_code;

  always #10 clk = ~clk;

  key_decoder #(.NUM_PLAYERS(NP), .KEYMAP(KMAP), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_50m(clk), .rst(rst), .kclk(kclk), .kdata(kdata),
    .player_btns(player_btns), .key_valid(key_valid), .key_code(key_code),
    .key_break(key_break), .frame_err(frame_err));

  typedef struct {
    logic [7:0]    code;
    logic          brk;
    logic [NB-1:0] btns;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0, failures = 0;
  int            errs_seen = 0, errs_exp = 0;
  bit            in_rst = 1'b1;
  logic [NB-1:0] m_btns = '0, cur_btns = '0;
  bit            m_brk = 1'b0, m_ext = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Model: prefix bytes arm flags; other bytes report and update every matching slot.
  task automatic model_byte(input logic [7:0] b);
    exp_t e;
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else begin
      if (!m_ext)
        for (int i = 0; i < NB; i++)
          if (KMAP[i*8 +: 8] == b) m_btns[i] = !m_brk;
      e.code = b; e.brk = m_brk; e.btns = m_btns;
      exp_q.push_back(e);
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (frame_err) errs_seen++;
    if (!in_rst) begin
      if (key_valid) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_key_valid actual_code=%0h expected=none", key_code);
        end else begin
          e = exp_q.pop_front();
          chk("key_code", 32'(key_code), 32'(e.code));
          chk("key_break", 32'(key_break), 32'(e.brk));
          cur_btns = e.btns;
        end
      end
      chk("player_btns", 32'(player_btns), 32'(cur_btns));
    end
  end

  task automatic tk(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_bit(input logic b);
    kdata = b; tk(H); kclk = 1'b0; tk(H); kclk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    if (bad_stop || (bad_par && PAR_EN)) errs_exp++;
    else model_byte(b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b ^ bad_par);
    send_bit(!bad_stop);
    kdata = 1'b1;
    tk(H);
  endtask

  task automatic send_partial(input int n);
    send_bit(1'b0);
    for (int i = 0; i < n; i++) send_bit(1'($urandom_range(1, 0)));
    kdata = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin tk(1); n++; end
    chk({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    tk(5);
    chk({name, "_frame_err_cnt"}, 32'(errs_seen), 32'(errs_exp));
  endtask

  task automatic reset_dut();
    in_rst = 1'b1;
    rst = 1'b1;
    tk(3);
    rst = 1'b0;
    m_btns = '0; cur_btns = '0; m_brk = 1'b0; m_ext = 1'b0;
    exp_q.delete();
    in_rst = 1'b0;
    tk(2);
  endtask

  initial begin
    #(20 * 150000);
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [7:0] b;
    reset_dut();
    chk("rst_btns", 32'(player_btns), 32'h0);
    chk("rst_valid", 32'(key_valid), 32'h0);
    chk("rst_err", 32'(frame_err), 32'h0);
    chk("rst_code", 32'(key_code), 32'h0);

    send_frame(8'h1D, 0, 0); wait_done("make_1d");
    chk("btns_1d", 32'(player_btns), 32'h001);
    send_frame(8'h5A, 0, 0); wait_done("make_5a");
    chk("btns_1d_5a", 32'(player_btns), 32'h201);
    send_frame(8'hF0, 0, 0); send_frame(8'h1D, 0, 0); wait_done("break_1d");
    chk("btns_rel_1d", 32'(player_btns), 32'h200);
    chk("break_flag", 32'(key_break), 32'h1);

    send_frame(8'hE0, 0, 0); send_frame(8'h75, 0, 0);
    send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h75, 0, 0);
    wait_done("ext_75");
    chk("btns_ext", 32'(player_btns), 32'h200);

    send_frame(8'h1D, 1, 0); wait_done("bad_par");
    chk("btns_bad_par", 32'(player_btns), PAR_EN ? 32'h200 : 32'h201);
    send_frame(8'hF0, 0, 0); send_frame(8'h1D, 0, 0); wait_done("norm");

    send_partial(5); tk(TMO + TMO / 20);
    errs_exp++;
    chk("timeout_err", 32'(errs_seen), 32'(errs_exp));
    send_frame(8'h29, 0, 0); wait_done("after_tmo");
    chk("btns_29", 32'(player_btns), 32'h210);

    // A break prefix must survive an abandoned frame.
    send_frame(8'hF0, 0, 0); send_partial(3); tk(TMO + 100); errs_exp++;
    send_frame(8'h29, 0, 0); wait_done("brk_across_tmo");
    chk("btns_29_rel", 32'(player_btns), 32'h200);

    send_bit(1'b1); tk(H); errs_exp++; wait_done("start_err");
    send_frame(8'h1D, 0, 1); wait_done("stop_err");
    chk("btns_stop_err", 32'(player_btns), 32'h200);

    send_frame(8'h1D, 0, 0); send_frame(8'h43, 0, 0); wait_done("pre_rst");
    chk("btns_pre_rst", 32'(player_btns), 32'h221);
    send_partial(6);
    reset_dut();
    chk("btns_mid_rst", 32'(player_btns), 32'h0);
    chk("mid_rst_no_err", 32'(errs_seen), 32'(errs_exp));
    send_frame(8'h1B, 0, 0); wait_done("post_rst");
    chk("btns_1b", 32'(player_btns), 32'h002);

    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(15, 0);
      if (r == 15) begin
        send_bit(1'b1); tk(H); errs_exp++;
      end else begin
        if (r < 8)       b = KMAP[$urandom_range(NB - 1, 0) * 8 +: 8];
        else if (r < 10) b = 8'hF0;
        else if (r < 11) b = 8'hE0;
        else             b = 8'($urandom);
        send_frame(b, $urandom_range(7, 0) == 0, $urandom_range(9, 0) == 0);
      end
      wait_done("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
